// File: rtl/dot_accum_if.sv
// rtl/dot_accum_if.sv - input beat and completed-sum handshake bundle for dot_accum
interface dot_accum_if #(
  parameter int SIZEI = 11,
  parameter int ACC_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic                    in_last;
  logic signed [SIZEI-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_first, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dot_accum.sv
// rtl/dot_accum.sv - saturating group accumulator for one dot_product lane
// Partials are summed per first/last group; completed sums queue in a FWFT FIFO.
module dot_accum #(
  parameter int SIZEI      = 11,
  parameter int ACC_W      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  dot_accum_if.slave    bus,
  output logic          err_restart,
  output logic [CW-1:0] fifo_count
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    err_q, err_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic signed [ACC_W-1:0] mem_data_q [FIFO_DEPTH];
  logic signed [ACC_W-1:0] mem_data_d [FIFO_DEPTH];
  logic                    mem_sat_q  [FIFO_DEPTH];
  logic                    mem_sat_d  [FIFO_DEPTH];

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fresh;
  logic                    sat_new;
  logic signed [ACC_W:0]   base_ext;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] clamped;

  assign bus.in_ready  = (count_q != CW'(FIFO_DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem_data_q[rd_ptr_q];
  assign bus.out_sat   = mem_sat_q[rd_ptr_q];
  assign fifo_count    = count_q;
  assign err_restart   = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && bus.in_last;
  assign pop    = bus.out_valid && bus.out_ready;
  // A first beat, or any beat with no open group, starts from zero.
  assign fresh  = bus.in_first || (state_q == IDLE);

  always_comb begin
    base_ext = fresh ? '0 : {acc_q[ACC_W-1], acc_q};
    sum      = base_ext + {{(ACC_W+1-SIZEI){bus.in_data[SIZEI-1]}}, bus.in_data};
    sat_new  = fresh ? 1'b0 : sat_q;
    clamped  = sum[ACC_W-1:0];
    if (sum > SUM_MAX) begin
      clamped = SUM_MAX[ACC_W-1:0];
      sat_new = 1'b1;
    end else if (sum < SUM_MIN) begin
      clamped = SUM_MIN[ACC_W-1:0];
      sat_new = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    err_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_data_d[i] = mem_data_q[i];
      mem_sat_d[i]  = mem_sat_q[i];
    end

    if (accept) begin
      err_d = bus.in_first && (state_q == ACC);
      if (bus.in_last) begin
        mem_data_d[wr_ptr_q] = clamped;
        mem_sat_d[wr_ptr_q]  = sat_new;
        wr_ptr_d             = wr_ptr_q + 1'b1;
        acc_d                = '0;
        sat_d                = 1'b0;
        state_d              = IDLE;
      end else begin
        acc_d   = clamped;
        sat_d   = sat_new;
        state_d = ACC;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_sat_q[i]  <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= mem_data_d[i];
        mem_sat_q[i]  <= mem_sat_d[i];
      end
    end
  end

endmodule
